// File: rtl/mult_fu_if.sv
// Issue/retire bundle between the RS lane, the multiply unit and the CDB arbiter.
// The master side is the RS/CDB environment; the slave side is the functional unit.
interface mult_fu_if #(
    parameter int XLEN = 32,
    parameter int PRF  = 64,
    parameter int ROB  = 32
);
    localparam int TW = $clog2(PRF);
    localparam int RW = $clog2(ROB);

    logic            start;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [1:0]      func;
    logic [TW-1:0]   dest_prf_idx;
    logic [RW-1:0]   rob_idx;
    logic            squash;
    logic            cdb_gnt;
    logic            occupied;
    logic            done_valid;
    logic [XLEN-1:0] done_data;
    logic [TW-1:0]   done_prf_idx;
    logic [RW-1:0]   done_rob_idx;

    modport master (
        output start, opa, opb, func, dest_prf_idx, rob_idx, squash, cdb_gnt,
        input  occupied, done_valid, done_data, done_prf_idx, done_rob_idx
    );

    modport slave (
        input  start, opa, opb, func, dest_prf_idx, rob_idx, squash, cdb_gnt,
        output occupied, done_valid, done_data, done_prf_idx, done_rob_idx
    );
endinterface

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU), shift-and-add over STAGES stages.
// Optional MULT_PERF_CNT_EN adds saturating retire/stall counters (perf_ops, perf_stall).
module mult_fu #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int PRF    = 64,
    parameter int ROB    = 32
) (
    input  logic        clock,
    input  logic        reset,
    mult_fu_if.slave    bus
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);
    localparam int W     = 2 * XLEN;
    localparam int CHUNK = W / STAGES;
    localparam int TW    = $clog2(PRF);
    localparam int RW    = $clog2(ROB);

    typedef struct packed {
        logic [1:0]    func;
        logic [TW-1:0] prf;
        logic [RW-1:0] rob;
        logic [W-1:0]  mcand;
        logic [W-1:0]  mplier;
        logic [W-1:0]  psum;
    } stage_t;

    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] vld_in;
    stage_t            s   [STAGES];
    stage_t            nxt [STAGES];
    stage_t            cap;
    logic              stall;

    // Consume the next CHUNK multiplier bits; multiplicand moves up to stay aligned.
    function automatic stage_t step(input stage_t in);
        stage_t o;
        o = in;
        for (int i = 0; i < CHUNK; i++)
            if (in.mplier[i]) o.psum = o.psum + (in.mcand << i);
        o.mcand  = in.mcand << CHUNK;
        o.mplier = in.mplier >> CHUNK;
        return o;
    endfunction

    always_comb begin
        cap        = '0;
        cap.func   = bus.func;
        cap.prf    = bus.dest_prf_idx;
        cap.rob    = bus.rob_idx;
        // MULH and MULHSU treat opa as signed; only MULH treats opb as signed.
        cap.mcand  = {{XLEN{bus.func[0] ^ bus.func[1] ? bus.opa[XLEN-1] : 1'b0}}, bus.opa};
        cap.mplier = {{XLEN{bus.func == 2'd1 ? bus.opb[XLEN-1] : 1'b0}}, bus.opb};
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign nxt[k] = step(cap);
            end else begin : g_rest
                assign nxt[k] = step(s[k-1]);
            end
        end
    endgenerate

    assign stall = vld_pipe[STAGES-1] & ~bus.cdb_gnt;

    always_comb begin
        vld_in    = vld_pipe << 1;
        vld_in[0] = bus.start;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int k = 0; k < STAGES; k++) s[k] <= '0;
        end else if (bus.squash) begin
            vld_pipe <= '0;
        end else if (!stall) begin
            vld_pipe <= vld_in;
            for (int k = 0; k < STAGES; k++) s[k] <= nxt[k];
        end
    end

    assign bus.occupied     = stall;
    assign bus.done_valid   = vld_pipe[STAGES-1];
    assign bus.done_data    = (s[STAGES-1].func == 2'd0) ? s[STAGES-1].psum[XLEN-1:0]
                                                         : s[STAGES-1].psum[W-1:XLEN];
    assign bus.done_prf_idx = s[STAGES-1].prf;
    assign bus.done_rob_idx = s[STAGES-1].rob;

    always_ff @(posedge clock) begin
        if (!reset) assert (!(bus.start && stall)) else $error("mult_fu: start while occupied, op dropped");
    end

`ifdef MULT_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (bus.done_valid && bus.cdb_gnt && perf_ops != 32'hFFFF_FFFF)
                perf_ops <= perf_ops + 32'd1;
            if (stall && perf_stall != 32'hFFFF_FFFF)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
